// File: rtl/prbs_pkg.sv
// prbs_pkg: shared LFSR polynomial, checker state enum and next-state fn.
// Used by the PRBS generator and checker alike.
package prbs_pkg;

  localparam int unsigned MAX_W = 32;
  localparam logic [15:0] POLY_DEFAULT = 16'h8BB7;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Galois step on the low w bits; upper bits of the result are zero.
  function automatic logic [MAX_W-1:0] lfsr_next(
    input logic [MAX_W-1:0] s,
    input logic [MAX_W-1:0] poly,
    input int unsigned      w
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] top;
    logic [MAX_W-1:0] r;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    top  = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    r    = (s << 1) ^ (|(s & top) ? poly : '0);
    return r & mask;
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// prbs_checker_if: receive word stream (in_valid/in_data), no backpressure.
// master drives the words, slave (the checker) samples them.
interface prbs_checker_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;

  modport master (
    output in_valid,
    output in_data
  );

  modport slave (
    input in_valid,
    input in_data
  );

endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising Galois LFSR checker with error counters.
// Ports: clk, reset_n, rx (slave), clear_counts, locked, err_pulse, counts.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] POLY       = POLY_DEFAULT,
  parameter int               LOCK_COUNT = 4,
  parameter int               LOSS_COUNT = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  prbs_checker_if.slave rx,
  input  logic          clear_counts,
  output logic          locked,
  output logic          err_pulse,
  output logic [31:0]   err_count,
  output logic [31:0]   checked_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] ref_d;
  logic [MW-1:0]    match_q;
  logic [MW-1:0]    match_d;
  logic [LW-1:0]    miss_q;
  logic [LW-1:0]    miss_d;
  logic             locked_q;
  logic             err_q;
  logic [31:0]      err_cnt_q;
  logic [31:0]      chk_cnt_q;

  logic             err_inc;
  logic             chk_inc;
  logic [WIDTH-1:0] nxt_in;
  logic [WIDTH-1:0] nxt_ref;
  logic             hit;
  logic             zero;
  logic [MW-1:0]    match_p1;
  logic [LW-1:0]    miss_p1;

  assign nxt_in = WIDTH'(lfsr_next(
    MAX_W'(rx.in_data), MAX_W'(POLY), WIDTH));
  assign nxt_ref = WIDTH'(lfsr_next(
    MAX_W'(ref_q), MAX_W'(POLY), WIDTH));

  assign hit      = (rx.in_data == ref_q);
  assign zero     = (rx.in_data == '0);
  assign match_p1 = match_q + MW'(1);
  assign miss_p1  = miss_q + LW'(1);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_inc = 1'b0;
    chk_inc = 1'b0;
    if (rx.in_valid) begin
      unique case (state_q)
        SEARCH: begin
          // all-zero is the LFSR lock-up word; never seed on it
          if (!zero) begin
            ref_d   = nxt_in;
            match_d = '0;
            state_d = TRACK;
          end
        end
        TRACK: begin
          if (hit) begin
            ref_d   = nxt_in;
            match_d = match_p1;
            if (match_p1 == MW'(LOCK_COUNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (!zero) begin
            ref_d   = nxt_in;
            match_d = '0;
          end else begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          // flywheel: keep predicting from ref so a bad word
          // cannot corrupt the reference
          chk_inc = 1'b1;
          ref_d   = nxt_ref;
          if (hit) begin
            miss_d = '0;
          end else begin
            err_inc = 1'b1;
            miss_d  = miss_p1;
            if (miss_p1 == LW'(LOSS_COUNT)) begin
              state_d = SEARCH;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SEARCH;
      ref_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= (state_d == LOCKED);
      err_q    <= err_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
      chk_cnt_q <= '0;
    end else if (clear_counts) begin
      err_cnt_q <= '0;
      chk_cnt_q <= '0;
    end else begin
      if (err_inc && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 32'd1;
      end
      if (chk_inc && (chk_cnt_q != '1)) begin
        chk_cnt_q <= chk_cnt_q + 32'd1;
      end
    end
  end

  assign locked        = locked_q;
  assign err_pulse     = err_q;
  assign err_count     = err_cnt_q;
  assign checked_count = chk_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: scoreboard bench with a behavioural reference model.
// Covers lock, single error, loss/relock, zero/gaps, counters, async reset.
module tb_prbs_checker;

  localparam int LOCK = 4;
  localparam int LOSS = 3;

  typedef struct {
    logic        lk;
    logic        ep;
    logic [31:0] ec;
    logic [31:0] cc;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        clear_counts;
  logic        locked;
  logic        err_pulse;
  logic [31:0] err_count;
  logic [31:0] checked_count;

  prbs_checker_if #(.WIDTH(16)) in_if ();

  prbs_checker #(
    .WIDTH(16),
    .POLY(16'h8BB7),
    .LOCK_COUNT(LOCK),
    .LOSS_COUNT(LOSS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx(in_if),
    .clear_counts(clear_counts),
    .locked(locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .checked_count(checked_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  exp_t sb[$];

  int          m_st;
  logic [15:0] m_ref;
  int          m_match;
  int          m_miss;
  logic [31:0] m_err;
  logic [31:0] m_chk;
  logic [15:0] g;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] nx(input logic [15:0] s);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h8BB7 : 16'h0000);
  endfunction

  task automatic model_reset();
    m_st = 0; m_ref = '0; m_match = 0; m_miss = 0;
    m_err = '0; m_chk = '0;
  endtask

  task automatic model(input logic v, input logic [15:0] d,
                       input logic clr, output exp_t e);
    logic ie;
    logic ic;
    ie = 1'b0;
    ic = 1'b0;
    if (v) begin
      case (m_st)
        0: if (d != 0) begin
          m_ref = nx(d); m_match = 0; m_st = 1;
        end
        1: if (d == m_ref) begin
          m_ref = nx(d); m_match++;
          if (m_match == LOCK) begin m_st = 2; m_miss = 0; end
        end else if (d != 0) begin
          m_ref = nx(d); m_match = 0;
        end else begin
          m_st = 0;
        end
        default: begin
          ic = 1'b1;
          if (d == m_ref) m_miss = 0;
          else begin
            ie = 1'b1; m_miss++;
            if (m_miss == LOSS) m_st = 0;
          end
          m_ref = nx(m_ref);
        end
      endcase
    end
    if (clr) begin
      m_err = '0; m_chk = '0;
    end else begin
      if (ie && m_err != 32'hFFFF_FFFF) m_err++;
      if (ic && m_chk != 32'hFFFF_FFFF) m_chk++;
    end
    e.lk = (m_st == 2);
    e.ep = ie;
    e.ec = m_err;
    e.cc = m_chk;
  endtask

  task automatic step(input logic v, input logic [15:0] d,
                      input logic clr);
    exp_t e;
    @(negedge clk);
    in_if.in_valid = v;
    in_if.in_data  = d;
    clear_counts   = clr;
    model(v, d, clr, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("locked", {31'd0, locked}, {31'd0, e.lk});
      check("err_pulse", {31'd0, err_pulse}, {31'd0, e.ep});
      check("err_count", err_count, e.ec);
      check("checked_count", checked_count, e.cc);
    end
    @(negedge clk);
    in_if.in_valid = 1'b0;
    clear_counts   = 1'b0;
  endtask

  task automatic good();
    step(1'b1, g, 1'b0);
    g = nx(g);
  endtask

  task automatic bad(input logic [15:0] flip);
    step(1'b1, g ^ flip, 1'b0);
    g = nx(g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    clear_counts   = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    model_reset();
    #12;
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_pulse", {31'd0, err_pulse}, 32'd0);
    check("rst_err", err_count, 32'd0);
    check("rst_chk", checked_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    g = 16'hFFFF;
    repeat (4) good();
    check("pre_lock", {31'd0, locked}, 32'd0);
    good();
    check("lock", {31'd0, locked}, 32'd1);
    check("lock_err", err_count, 32'd0);

    bad(16'h0001);
    check("single_err", err_count, 32'd1);
    check("single_lk", {31'd0, locked}, 32'd1);
    repeat (6) good();
    check("flywheel", err_count, 32'd1);

    step(1'b0, 16'h1234, 1'b1);
    repeat (3) bad(16'h0100);
    check("loss_err", err_count, 32'd3);
    check("loss_lk", {31'd0, locked}, 32'd0);
    repeat (4) good();
    check("relock_pre", {31'd0, locked}, 32'd0);
    good();
    check("relock", {31'd0, locked}, 32'd1);

    do_reset();
    step(1'b1, 16'h0000, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    g = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int k = 0; k < gap; k++) step(1'b0, $urandom(), 1'b0);
      good();
    end
    check("gap_lock", {31'd0, locked}, 32'd1);
    check("gap_err", err_count, 32'd0);

    step(1'b1, g ^ 16'h8000, 1'b1);
    g = nx(g);
    check("clr_wins", err_count, 32'd0);
    good();

    @(negedge clk);
    force dut.err_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.err_cnt_q;
    m_err = 32'hFFFF_FFFE;
    repeat (3) bad(16'h0010);
    check("sat_hold", err_count, 32'hFFFF_FFFF);

    g = 16'h1ACE;
    repeat (5) good();
    check("pre_rst_lk", {31'd0, locked}, 32'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_locked", {31'd0, locked}, 32'd0);
    check("arst_pulse", {31'd0, err_pulse}, 32'd0);
    check("arst_err", err_count, 32'd0);
    check("arst_chk", checked_count, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) good();
    check("arst_search", {31'd0, locked}, 32'd0);
    good();
    check("arst_relock", {31'd0, locked}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Downstream consumer of the 16-bit Galois LFSR pattern generator. Accepts a stream of LFSR state words, self-synchronises to the sequence by predicting each next word with the same polynomial, and then counts mismatches. It is used as the link and datapath integrity monitor at the receive end of any path fed by the generator.

## Interface
- `WIDTH`, 16: word and LFSR width.
- `POLY`, 16'h8BB7: feedback taps (x^16+x^15+x^11+x^9+x^8+x^7+x^5+x^4+x^2+x+1, leading term implicit).
- `LOCK_COUNT`, 4: consecutive correct predictions needed to declare lock (≥1).
- `LOSS_COUNT`, 3: consecutive mismatches while locked that drop lock (≥1).
- `clk` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_data` is sampled this cycle.
- `in_data` in WIDTH: received LFSR state word.
- `clear_counts` in 1: synchronous clear of both counters.
- `locked` out 1: checker is in LOCKED.
- `err_pulse` out 1: one-cycle strobe per mismatched word while locked.
- `err_count` out 32: saturating mismatch count.
- `checked_count` out 32: saturating count of words compared while locked.

## Operation
- Prediction is `next(s) = (s << 1) ^ (s[WIDTH-1] ? POLY : 0)`, truncated to WIDTH bits. Internal register `ref` holds the expected next word.
- Cycles with `in_valid`=0 change nothing; gaps of any length are allowed.
- States: SEARCH, TRACK, LOCKED. Reset state: SEARCH.
- SEARCH, valid word: if `in_data`==0 (lock-up state), stay in SEARCH. Otherwise set `ref<=next(in_data)`, `match_cnt<=0`, and go to TRACK.
- TRACK, valid word:
  - Match: `ref<=next(in_data)` and `match_cnt++`. When `match_cnt+1==LOCK_COUNT`, go to LOCKED with `miss_cnt<=0`.
  - Mismatch, nonzero word: reseed `ref<=next(in_data)`, `match_cnt<=0`, stay in TRACK.
  - Mismatch, zero word: go to SEARCH.
- LOCKED, valid word: `checked_count++`, and `ref<=next(ref)` (flywheel, never reseeded from data).
  - Match: `miss_cnt<=0`.
  - Mismatch: `err_pulse`, `err_count++`, `miss_cnt++`. When `miss_cnt+1==LOSS_COUNT`, go to SEARCH.
- Counters saturate at 32'hFFFF_FFFF and do not wrap. They are cleared only by reset or `clear_counts`.
- `clear_counts` together with an increment in the same cycle: the clear wins, the counter becomes 0, and that increment is dropped. `clear_counts` does not affect the state.
- Mismatches in TRACK or SEARCH are never counted and never pulse `err_pulse`.

## Timing
- All outputs are registered. Reset values: `locked`=0, `err_pulse`=0, `err_count`=0, `checked_count`=0.
- Internal reset values: `ref`=0, `match_cnt`=0, `miss_cnt`=0.
- `reset_n` asserted mid-stream: everything returns to the reset values immediately (asynchronously). The checker restarts from SEARCH on the first valid word after release.
- Latency: `err_pulse` and count updates appear the cycle after the offending word is sampled.
- `locked` rises the cycle after the LOCK_COUNT-th matching word. It falls the cycle after the LOSS_COUNT-th consecutive miss.
- The input is accepted back-to-back every cycle, with no backpressure.

## Structure
- Shared package `prbs_pkg` holds the default POLY, the state enum (SEARCH/TRACK/LOCKED), and a pure function `lfsr_next(state, poly)`. The generator reuses the same function.
- No sub-module is needed. A single module with a state register, `ref`, two small run-length counters, and two saturating counters.

## Test plan
- Lock: reset, then feed FFFF, 7449, E892, 5A93, B526 on consecutive cycles. Required: `locked`=1 one cycle after B526, and `err_count`=0.
- Single error: while locked, replace one expected word with a one-bit flip. Required: exactly one `err_pulse`, `err_count`=1, still locked, and the following correct words all match (flywheel).
- Loss: while locked, feed 3 consecutive wrong words. Required: `err_count`=3, `locked` falls after the 3rd, and re-lock succeeds after 1+4 clean words.
- Zero and gaps: feed 0000 in SEARCH, which must be ignored. Then feed the lock sequence with random `in_valid` gaps. Required: same lock result as scenario 1.
- Counter rules: assert `clear_counts` on the same cycle as an error increment; required result is `err_count`=0. Force the counter near saturation; required result is that it holds at FFFF_FFFF.
- Async reset mid-lock: pulse `reset_n` low between clock edges. Required: all outputs are 0 immediately, and the checker is in SEARCH.
